// File: rtl/hbridge_burst_seq.sv
// hbridge_burst_seq
//   Gate-drive sequencer for the NMR transmitter H-bridge. Runs a burst of
//   `reps` identical periods of `period` clk cycles. In each period Q1Q8 (outer
//   main-leg window) is high for in-period offsets [0, t_end) and Q3Q6 (inner
//   window) is high for [t_rise, t_fall). Q3Q6 is always nested inside Q1Q8.
//
// Ports
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   load     in   capture t_rise/t_fall/t_end/period/reps (accepted in IDLE only)
//   t_rise   in   CNT_W  offset of Q3Q6 rising edge
//   t_fall   in   CNT_W  offset of Q3Q6 falling edge
//   t_end    in   CNT_W  offset of Q1Q8 falling edge
//   period   in   CNT_W  period length in cycles
//   reps     in   REP_W  periods per burst
//   start    in   one-cycle burst start request
//   abort    in   terminate the running burst immediately (no done)
//   Q1Q8     out  main-leg gate drive
//   Q3Q6     out  inner-leg gate drive
//   busy     out  burst in progress
//   done     out  one-cycle pulse after normal completion
//   cfg_err  out  shadow configuration invalid
module hbridge_burst_seq #(
    parameter int CNT_W = 8,
    parameter int REP_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] t_rise,
    input  logic [CNT_W-1:0] t_fall,
    input  logic [CNT_W-1:0] t_end,
    input  logic [CNT_W-1:0] period,
    input  logic [REP_W-1:0] reps,
    input  logic             start,
    input  logic             abort,
    output logic             Q1Q8,
    output logic             Q3Q6,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   pc_reg, pc_next;
    logic [REP_W-1:0]   rc_reg, rc_next;

    logic [CNT_W-1:0]   t_rise_reg, t_fall_reg, t_end_reg, period_reg;
    logic [REP_W-1:0]   reps_reg;
    logic               cfg_err_reg;

    logic               q1q8_reg, q1q8_next;
    logic               q3q6_reg, q3q6_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;

    logic               cfg_valid;
    logic               load_ok;
    logic               period_last;
    logic               burst_last;

    // Strict ordering guarantees at least one guard cycle between each Q3Q6
    // edge and the enclosing Q1Q8 edge.
    assign cfg_valid = (t_rise != '0) && (t_rise < t_fall) && (t_fall < t_end)
                    && (t_end <= period) && (reps != '0);

    assign load_ok     = load && (state_reg == IDLE);
    assign period_last = (pc_reg == period_reg - CNT_W'(1));
    assign burst_last  = period_last && (rc_reg == reps_reg - REP_W'(1));

    // State, counters, shadow configuration and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            pc_reg      <= '0;
            rc_reg      <= '0;
            t_rise_reg  <= '0;
            t_fall_reg  <= '0;
            t_end_reg   <= '0;
            period_reg  <= '0;
            reps_reg    <= '0;
            cfg_err_reg <= 1'b1;   // all-zero shadow is invalid
            q1q8_reg    <= 1'b0;
            q3q6_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            rc_reg    <= rc_next;
            if (load_ok) begin
                t_rise_reg  <= t_rise;
                t_fall_reg  <= t_fall;
                t_end_reg   <= t_end;
                period_reg  <= period;
                reps_reg    <= reps;
                cfg_err_reg <= !cfg_valid;
            end
            q1q8_reg <= q1q8_next;
            q3q6_reg <= q3q6_next;
            busy_reg <= busy_next;
            done_reg <= done_next;
        end
    end

    // Next-state and counter advance.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        rc_next    = rc_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && !abort && !cfg_err_reg) begin
                    state_next = RUN;
                    pc_next    = '0;
                    rc_next    = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                    pc_next    = '0;
                    rc_next    = '0;
                end else if (burst_last) begin
                    state_next = IDLE;
                    pc_next    = '0;
                    rc_next    = '0;
                    done_next  = 1'b1;
                end else if (period_last) begin
                    pc_next = '0;
                    rc_next = rc_reg + REP_W'(1);
                end else begin
                    pc_next = pc_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode from the next counter value so the registered outputs line
    // up with the counter cycle they describe.
    always_comb begin
        busy_next = (state_next == RUN);
        q1q8_next = busy_next && (pc_next < t_end_reg);
        q3q6_next = busy_next && (pc_next >= t_rise_reg) && (pc_next < t_fall_reg);
    end

    assign Q1Q8    = q1q8_reg;
    assign Q3Q6    = q3q6_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign cfg_err = cfg_err_reg;

endmodule

// File: tb/tb_hbridge_burst_seq.sv
module tb_hbridge_burst_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [7:0] t_rise = '0, t_fall = '0, t_end = '0, period = '0;
    logic [7:0] reps = '0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       Q1Q8, Q3Q6, busy, done, cfg_err;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Expected vector {Q1Q8, Q3Q6, busy, done, cfg_err} per cycle.
    logic [4:0] exp_q[$];
    string      tag_q[$];

    hbridge_burst_seq #(.CNT_W(8), .REP_W(8)) dut (
        .clk(clk), .reset(reset), .load(load),
        .t_rise(t_rise), .t_fall(t_fall), .t_end(t_end), .period(period), .reps(reps),
        .start(start), .abort(abort),
        .Q1Q8(Q1Q8), .Q3Q6(Q3Q6), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // Reference for a burst whose start is sampled at the edge entering cycle 1.
    // kill_at > 0: abort (or reset) driven in cycle kill_at, zeroing from kill_at+1.
    function automatic logic [4:0] expv(input int c, input int rise, input int fall,
                                        input int tend, input int per, input int nreps,
                                        input int kill_at, input bit kill_rst);
        int len, p;
        len = per * nreps;
        if (kill_at > 0 && c > kill_at) return kill_rst ? 5'b00001 : 5'b00000;
        if (c >= 1 && c <= len) begin
            p = (c - 1) % per;
            return {(p < tend), (p >= rise && p < fall), 1'b1, 1'b0, 1'b0};
        end
        if (c == len + 1) return 5'b00010;
        return 5'b00000;
    endfunction

    task automatic check();
        logic [4:0] obs, want;
        string      tag;
        obs = {Q1Q8, Q3Q6, busy, done, cfg_err};
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty cycle %0d: got %b want <none>", cyc, obs);
        end else begin
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            assert (obs === want) else begin
                bad++;
                $error("FAIL %s cycle %0d: got Q1Q8,Q3Q6,busy,done,cfg_err=%b want %b",
                       tag, cyc, obs, want);
            end
        end
    endtask

    // Push one expectation, advance one edge, compare.
    task automatic step(input logic [4:0] e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk); #1;
        cyc++;
        check();
    endtask

    task automatic do_load(input int r, input int f, input int e, input int p,
                           input int n, input logic [4:0] e_after, input string tag);
        t_rise = 8'(r); t_fall = 8'(f); t_end = 8'(e); period = 8'(p); reps = 8'(n);
        load = 1'b1;
        step(e_after, tag);
        load = 1'b0;
    endtask

    // Start in the current cycle (cycle 0) and follow the burst for len cycles.
    // mid_at > 0: pulse load with a different valid config plus start mid-burst.
    task automatic run(input int r, input int f, input int e, input int p, input int n,
                       input int kill_at, input bit kill_rst, input int mid_at,
                       input int len, input string tag);
        for (int c = 1; c <= len; c++) begin
            exp_q.push_back(expv(c, r, f, e, p, n, kill_at, kill_rst));
            tag_q.push_back(tag);
        end
        cyc = 0;
        start = 1'b1;
        for (int c = 1; c <= len; c++) begin
            @(posedge clk); #1;
            cyc = c;
            start = 1'b0; abort = 1'b0; reset = 1'b0; load = 1'b0;
            check();
            if (c == kill_at) begin
                if (kill_rst) reset = 1'b1;
                else abort = 1'b1;
            end
            if (c == mid_at) begin
                t_rise = 8'd1; t_fall = 8'd2; t_end = 8'd3; period = 8'd4; reps = 8'd1;
                load = 1'b1;
                start = 1'b1;
            end
        end
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        step(5'b00001, "reset_state");
        step(5'b00001, "reset_state");
        reset = 1'b0;
        start = 1'b1;
        step(5'b00001, "start_no_cfg");
        start = 1'b0;

        // Basic burst: 2/5/8/10 x3
        do_load(2, 5, 8, 10, 3, 5'b00000, "load_ok");
        run(2, 5, 8, 10, 3, 0, 1'b0, 0, 33, "burst_basic");

        // Invalid: t_rise == t_fall
        do_load(3, 3, 8, 10, 3, 5'b00001, "cfg_err_rise_eq_fall");
        start = 1'b1;
        for (int i = 0; i < 6; i++) step(5'b00001, "start_ignored_err1");
        start = 1'b0;

        // Invalid: reps == 0
        do_load(2, 5, 8, 10, 0, 5'b00001, "cfg_err_reps0");
        start = 1'b1;
        for (int i = 0; i < 6; i++) step(5'b00001, "start_ignored_err2");
        start = 1'b0;

        // Abort at cycle 14, then a fresh full burst
        do_load(2, 5, 8, 10, 3, 5'b00000, "reload_ok");
        run(2, 5, 8, 10, 3, 14, 1'b0, 0, 36, "burst_abort");
        run(2, 5, 8, 10, 3, 0, 1'b0, 0, 33, "burst_after_abort");

        // Abort overrides start in IDLE
        start = 1'b1; abort = 1'b1;
        step(5'b00000, "abort_over_start");
        step(5'b00000, "abort_over_start");
        start = 1'b0; abort = 1'b0;

        // t_end == period: Q1Q8 continuous
        do_load(1, 4, 6, 6, 2, 5'b00000, "load_tend_eq_period");
        run(1, 4, 6, 6, 2, 0, 1'b0, 0, 15, "burst_tend_eq_period");

        // Load/start during a burst are ignored; next burst keeps old timing
        run(1, 4, 6, 6, 2, 0, 1'b0, 5, 15, "burst_mid_load");
        run(1, 4, 6, 6, 2, 0, 1'b0, 0, 15, "burst_shadow_kept");

        // Reset during cycle 5 of a burst
        do_load(2, 5, 8, 10, 3, 5'b00000, "load_before_reset");
        run(2, 5, 8, 10, 3, 5, 1'b1, 0, 10, "burst_reset");
        start = 1'b1;
        for (int i = 0; i < 5; i++) step(5'b00001, "start_after_reset");
        start = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hbridge_burst_seq.md
Name: hbridge_burst_seq

Overview:
- Parametrised successor to the single-shot Q1Q8/Q3Q6 gate-drive sequencer in the NMR transmitter H-bridge path.
- Generates a programmable burst of N identical H-bridge periods.
  - Q1Q8 is the outer (main-leg) window.
  - Q3Q6 is the nested inner window.
  - Windows are defined by rise, fall and end offsets and a repeat period.
- Adds start/abort control, busy/done status and configuration validation.
- Sits between the register/sequencer interface and the bridge gate drivers.

Parameters:
- CNT_W, 8, width of all in-period offsets and the period counter.
- REP_W, 8, width of the repetition count.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- load  in  1  one-cycle strobe; captures t_rise/t_fall/t_end/period/reps into shadow registers.
- t_rise  in  CNT_W  in-period offset of the Q3Q6 rising edge.
- t_fall  in  CNT_W  in-period offset of the Q3Q6 falling edge.
- t_end  in  CNT_W  in-period offset of the Q1Q8 falling edge.
- period  in  CNT_W  period length in clk cycles.
- reps  in  REP_W  number of periods in the burst.
- start  in  1  one-cycle burst start request.
- abort  in  1  terminate the burst immediately.
- Q1Q8  out  1  main-leg gate drive.
- Q3Q6  out  1  inner-leg gate drive.
- busy  out  1  high while a burst runs.
- done  out  1  one-cycle pulse on normal burst completion.
- cfg_err  out  1  high while the shadow configuration is invalid.

Behaviour:
- Reset (synchronous, active-high; takes effect at the next clk edge, including mid-burst):
  - Q1Q8=0, Q3Q6=0, busy=0, done=0, state=IDLE.
  - Shadow registers cleared to 0, so cfg_err=1 after reset.
- Shadow configuration:
  - load is accepted only in IDLE; load while busy is ignored.
  - Valid iff 0 < t_rise < t_fall < t_end <= period and reps >= 1.
  - cfg_err is registered and updates the cycle after load.
- States: IDLE, RUN.
- IDLE -> RUN:
  - Taken when start=1, abort=0 and cfg_err=0.
  - start with cfg_err=1 is ignored and no done is produced.
  - start in RUN is ignored.
- RUN counters:
  - Period counter pc runs 0..period-1.
  - Repetition counter rc runs 0..reps-1.
  - If start is accepted at edge k, the cycle after edge k has pc=0, rc=0 and busy=1.
- Output windows (registered, no combinational path from inputs to outputs), for each RUN cycle:
  - Q1Q8 = (pc < t_end).
  - Q3Q6 = (t_rise <= pc < t_fall).
  - Q3Q6 is therefore always nested inside Q1Q8, with at least one cycle of guard on each side.
- Counter advance and completion:
  - pc wraps from period-1 to 0 and rc increments.
  - At pc=period-1 with rc=reps-1: return to IDLE; the next cycle has busy=0 and done=1 for one cycle.
  - Burst length is exactly period*reps cycles.
- t_end == period is legal: Q1Q8 stays high continuously across period boundaries.
- abort:
  - In RUN, abort at edge k gives Q1Q8=Q3Q6=0, busy=0, state=IDLE in the following cycle, with no done.
  - In IDLE, abort overrides a simultaneous start.
- Counter widths are exactly CNT_W/REP_W; no wrap beyond the programmed limits is possible with valid configuration.
- Outputs are 0 whenever the state is IDLE.

Test Plan:
- Reset, then load t_rise=2, t_fall=5, t_end=8, period=10, reps=3; start at cycle 0:
  - Q1Q8 high cycles 1-8, 11-18, 21-28.
  - Q3Q6 high cycles 3-5, 13-15, 23-25.
  - busy high cycles 1-30; done=1 at cycle 31 only.
- Load t_rise=3, t_fall=3 (and, separately, reps=0): cfg_err=1 the cycle after load; a subsequent start leaves busy=0, outputs 0 and done=0.
- Same configuration as the first test with abort at cycle 14: Q1Q8=Q3Q6=busy=0 from cycle 15 on; done never asserts; a fresh start runs a full burst again.
- Load with t_end=period=6, t_rise=1, t_fall=4, reps=2: Q1Q8 high continuously cycles 1-12; Q3Q6 high cycles 2-4 and 8-10; done at cycle 13.
- During a burst, pulse load with new values and pulse start: the burst is unaffected; the shadow registers keep the old values (verified by the next burst's timing).
- Assert reset at cycle 5 of a burst: all outputs 0 at cycle 6; cfg_err=1; start without reload is ignored.
